// File: rtl/ud_cnt_pkg.sv
// Shared types and width helpers for the up/down counter command front end.
package ud_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DN,
    CMD_LOAD
  } cmd_t;

  localparam int DB_CYCLES_DEF = 4;
  localparam int RPT_DELAY_DEF = 16;
  localparam int RPT_RATE_DEF  = 4;

  // Width of a counter that runs 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer; emits the stable level and a
// one-cycle press pulse registered on the same edge the level rises.
module btn_debounce
  import ud_cnt_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int DB_W = cnt_w(DB_CYCLES);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != level) begin
        // Reaching DB_CYCLES differing samples flips the stable level.
        if (cnt == DB_W'(DB_CYCLES - 1)) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ud_cnt_cmd_gen.sv
// Button-to-command front end for the 4-bit up/down counter.
// Auto-repeat of held UP/DN is built only when UD_CNT_AUTO_REPEAT_EN is defined.
module ud_cnt_cmd_gen
  import ud_cnt_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RPT_DELAY = RPT_DELAY_DEF,
  parameter int RPT_RATE  = RPT_RATE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_LD,
  input  logic [3:0] SW,
  output logic [3:0] D,
  output logic       LD,
  output logic       UD,
  output logic       CE
);

  logic up_level, dn_level, ld_level;
  logic up_press, dn_press, ld_press;
  cmd_t press_cmd, cmd;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .CLK(CLK), .RST(RST), .btn(BTN_UP), .level(up_level), .press(up_press)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .CLK(CLK), .RST(RST), .btn(BTN_DN), .level(dn_level), .press(dn_press)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
    .CLK(CLK), .RST(RST), .btn(BTN_LD), .level(ld_level), .press(ld_press)
  );

  // Same-cycle presses: LD wins over UP over DN; losers are dropped.
  always_comb begin
    press_cmd = CMD_NONE;
    if (ld_press)      press_cmd = CMD_LOAD;
    else if (up_press) press_cmd = CMD_UP;
    else if (dn_press) press_cmd = CMD_DN;
  end

`ifdef UD_CNT_AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RPT_W   = cnt_w(RPT_MAX);

  rpt_state_t       state, state_n;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n;
  logic             trk_dn, trk_dn_n;
  logic             trk_level;
  logic             unused_levels;

  assign trk_level     = trk_dn ? dn_level : up_level;
  assign unused_levels = ld_level;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      trk_dn  <= 1'b0;
    end else begin
      state   <= state_n;
      rpt_cnt <= rpt_cnt_n;
      trk_dn  <= trk_dn_n;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n   = state;
    rpt_cnt_n = rpt_cnt;
    trk_dn_n  = trk_dn;
    cmd       = press_cmd;
    if (ld_press || (up_level && dn_level)) begin
      state_n = IDLE;
    end else if (up_press || dn_press) begin
      state_n   = HOLD;
      trk_dn_n  = !up_press;
      rpt_cnt_n = '0;
    end else begin
      case (state)
        HOLD, REPEAT: begin
          if (!trk_level) begin
            state_n = IDLE;
          end else if (rpt_cnt == RPT_W'(((state == HOLD) ? RPT_DELAY : RPT_RATE) - 1)) begin
            state_n   = REPEAT;
            rpt_cnt_n = '0;
            cmd       = trk_dn ? CMD_DN : CMD_UP;
          end else begin
            rpt_cnt_n = rpt_cnt + RPT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
`else
  logic unused_levels;
  assign unused_levels = ^{up_level, dn_level, ld_level};
  assign cmd           = press_cmd;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D  <= '0;
      LD <= 1'b0;
      UD <= 1'b0;
      CE <= 1'b0;
    end else begin
      CE <= (cmd != CMD_NONE);
      LD <= (cmd == CMD_LOAD);
      case (cmd)
        CMD_LOAD: D  <= SW;
        CMD_UP:   UD <= 1'b1;
        CMD_DN:   UD <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ud_cnt_cmd_gen.sv
// Directed bench: expected commands are queued as buttons are driven and
// compared by a monitor whenever CE is seen.
module tb_ud_cnt_cmd_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0, BTN_DN = 1'b0, BTN_LD = 1'b0;
  logic [3:0] SW = 4'h0;
  logic [3:0] D;
  logic       LD, UD, CE;

  typedef struct {
    int         cyc;
    logic       ld;
    logic       ud;
    logic [3:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic       exp_ud = 1'b0;
  logic [3:0] exp_d  = 4'h0;

  ud_cnt_cmd_gen #(.DB_CYCLES(4), .RPT_DELAY(16), .RPT_RATE(4)) dut (
    .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
    .SW(SW), .D(D), .LD(LD), .UD(UD), .CE(CE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push(input int c, input logic ld, input logic ud, input logic [3:0] d);
    exp_t e;
    e.cyc = c; e.ld = ld; e.ud = ud; e.d = d;
    exp_q.push_back(e);
    exp_ud = ud;
    exp_d  = d;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_d"}, int'(D), 0);
    check({tag, "_ld"}, int'(LD), 0);
    check({tag, "_ud"}, int'(UD), 0);
    check({tag, "_ce"}, int'(CE), 0);
  endtask

  // Monitor: every CE must match the oldest queued command.
  always @(negedge CLK) begin
    if (CE === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_ce: observed CE at cycle %0d expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ce_cycle", cyc, e.cyc);
        check("ce_ld", int'(LD), int'(e.ld));
        check("ce_ud", int'(UD), int'(e.ud));
        check("ce_d", int'(D), int'(e.d));
      end
    end
  end

  initial begin
    int c;
    // Reset state
    wait_cyc(3);
    check_outputs_zero("reset");
    RST = 1'b0;
    wait_cyc(5);

    // Single UP press held 10 cycles
    c = cyc;
    BTN_UP = 1'b1;
    push(c + 7, 1'b0, 1'b1, exp_d);
    wait_cyc(10);
    BTN_UP = 1'b0;
    wait_cyc(15);

    // 3-cycle glitch: no command
    BTN_UP = 1'b1;
    wait_cyc(3);
    BTN_UP = 1'b0;
    wait_cyc(15);

    // LD press, SW changed afterwards
    SW = 4'hA;
    c = cyc;
    BTN_LD = 1'b1;
    push(c + 7, 1'b1, exp_ud, 4'hA);
    wait_cyc(10);
    BTN_LD = 1'b0;
    SW = 4'h5;
    wait_cyc(15);
    check("d_hold", int'(D), 'hA);
    check("ud_hold", int'(UD), 1);

    // LD+UP+DN together: load wins
    SW = 4'h3;
    c = cyc;
    {BTN_LD, BTN_UP, BTN_DN} = 3'b111;
    push(c + 7, 1'b1, exp_ud, 4'h3);
    wait_cyc(10);
    {BTN_LD, BTN_UP, BTN_DN} = 3'b000;
    wait_cyc(15);

    // UP+DN together and held: one UP, never repeats
    c = cyc;
    {BTN_UP, BTN_DN} = 2'b11;
    push(c + 7, 1'b0, 1'b1, exp_d);
    wait_cyc(30);
    {BTN_UP, BTN_DN} = 2'b00;
    wait_cyc(15);

    // DN held 40 cycles: level falls after edge c+46
    c = cyc;
    BTN_DN = 1'b1;
    push(c + 7, 1'b0, 1'b0, exp_d);
`ifdef UD_CNT_AUTO_REPEAT_EN
    for (int t = c + 23; t <= c + 46; t += 4) push(t, 1'b0, 1'b0, exp_d);
`endif
    wait_cyc(40);
    BTN_DN = 1'b0;
    wait_cyc(20);

    // Reset in the middle of UP repeats
    c = cyc;
    BTN_UP = 1'b1;
    push(c + 7, 1'b0, 1'b1, exp_d);
`ifdef UD_CNT_AUTO_REPEAT_EN
    push(c + 23, 1'b0, 1'b1, exp_d);
    push(c + 27, 1'b0, 1'b1, exp_d);
`endif
    wait_cyc(29);
    RST = 1'b1;
    BTN_UP = 1'b0;
    wait_cyc(1);
    check_outputs_zero("mid_reset");
    wait_cyc(2);
    RST = 1'b0;
    wait_cyc(25);
    check("post_reset_ce", int'(CE), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ud_cnt_cmd_gen.md
# ud_cnt_cmd_gen

Front-end command generator for the 4-bit up/down counter. It turns raw push-buttons and a 4-bit switch value into the counter's control inputs (D, LD, UD, CE). Each button is synchronized and debounced, and each press becomes a single-cycle command. Held up/down buttons can optionally auto-repeat. It sits between the board I/O and the counter, in the same clock domain as the counter.

## Interface
Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronized button must hold a new level before its debounced state changes (≥2).
- RPT_DELAY, 16: cycles from the first command of a held press to the first repeat (≥2).
- RPT_RATE, 4: cycles between successive repeats (≥2).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- BTN_UP  in  1  raw up button, asynchronous, active-high.
- BTN_DN  in  1  raw down button, asynchronous, active-high.
- BTN_LD  in  1  raw load button, asynchronous, active-high.
- SW  in  4  load value; treated as quasi-static.
- D  out  4  load value to counter, registered.
- LD  out  1  load command, registered.
- UD  out  1  direction (1 = up, 0 = down), registered.
- CE  out  1  command strobe, one-cycle pulse, registered.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: a per-button counter increments while the synchronized level differs from the stable level, and clears when the levels match. When the count reaches DB_CYCLES, the stable level flips and the counter clears.
- A press is a 0→1 transition of a stable level. Releases generate nothing.
- On a press, one command is issued:
  - LD: CE=1, LD=1, D=SW sampled that cycle. UD holds its previous value.
  - UP: CE=1, LD=0, UD=1.
  - DN: CE=1, LD=0, UD=0.
- Simultaneous presses in the same cycle: priority is LD > UP > DN. The losing presses are dropped and are not queued.
- Between commands, CE=0 and LD=0. D and UD hold their last values.
- Repeat FSM states:
  - IDLE: no repeat active.
  - HOLD: waiting RPT_DELAY cycles after the press command.
  - REPEAT: issue the same command every RPT_RATE cycles.
- FSM transitions:
  - An UP or DN press moves the FSM to HOLD, tracking that button.
  - An LD press moves it to IDLE; LD never repeats.
  - HOLD moves to REPEAT on expiry, issuing a command that same cycle.
  - Any state moves to IDLE when the tracked button's stable level goes to 0, with no further commands.
  - A new press in HOLD or REPEAT issues its own command and restarts HOLD for the new button, or goes to IDLE if it was LD.
  - If both UP and DN are stably high, the FSM goes to IDLE.
- RST clears:
  - synchronizers, stable levels, counters and FSM (IDLE);
  - outputs: D=0, LD=0, UD=0, CE=0.
- A button held across reset release is seen as a fresh press once debounced.

## Timing
- Press latency: a raw rising level first sampled at edge k, held steady, gives CE=1 in the cycle after edge k+DB_CYCLES+2. That is DB_CYCLES+3 cycles in total.
- First repeat: CE rises RPT_DELAY cycles after the press CE.
- Later repeats: CE rises every RPT_RATE cycles. CE is never high for two consecutive cycles.
- Release latency: a release stops repeats within DB_CYCLES+3 cycles of the raw falling level. No CE is issued after the stable level falls.
- Glitches shorter than DB_CYCLES cycles after synchronization produce no command.

## Configuration
- Macro: UD_CNT_AUTO_REPEAT_EN.
- Defined: the repeat FSM is present as described above.
- Undefined: the FSM and its delay/rate counters are removed. Each press yields exactly one command, and RPT_DELAY and RPT_RATE are ignored. Debounce, priority and latency are unchanged.

## Structure
- Shared package ud_cnt_pkg holds:
  - the repeat FSM state enum (IDLE, HOLD, REPEAT);
  - a command-code typedef (NONE, UP, DN, LOAD);
  - width-derivation constants for the debounce and repeat counters.
- Sub-module btn_debounce (synchronizer + debouncer; outputs the stable level and a press pulse), instantiated three times.

## Test plan
- Reset: RST=1 mid-repeat → next cycle D=0, LD=0, UD=0, CE=0. After release with no buttons pressed, CE stays 0.
- Single UP press, DB_CYCLES=4, held 10 cycles: exactly one CE with UD=1, LD=0, 7 cycles after the first high sample. A 3-cycle glitch produces no CE.
- LD press with SW=4'hA: one CE with LD=1, D=4'hA. Changing SW afterwards leaves D=4'hA.
- Simultaneous LD+UP+DN press: one CE with LD=1. UP+DN only: one CE with UD=1.
- DN held 40 cycles with repeat enabled (16/4): CEs with UD=0 at t0, t0+16, t0+20, t0+24, and so on. After release, no further CE.
- Same DN hold with UD_CNT_AUTO_REPEAT_EN undefined: exactly one CE.
